// File: rtl/stack_ctrl.sv
// ---------------------------------------------------------------------------
// stack_ctrl -- operand-stack controller for the wasm CPU core.
//
// The top of stack lives in a register. Deeper entries spill to an external
// single-port synchronous RAM. Entry k of the stack (k = 0 is the bottom) sits
// at RAM address k. The TOS register holds entry depth-1.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   op_valid/op_ready   request handshake (op: 0 NOP, 1 PUSH, 2 POP, 3 REPLACE)
//   op_data             value for PUSH / REPLACE
//   tos, empty, depth   CPU-visible stack view (registered)
//   trap                0 none, 1 overflow, 2 underflow (sticky until reset)
//   mem_addr/we/wdata   RAM request (combinational in the accept cycle)
//   mem_rdata           RAM read data, one cycle after mem_addr
// ---------------------------------------------------------------------------
module stack_ctrl #(
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  op_data,
  output logic              op_ready,
  output logic [WIDTH-1:0]  tos,
  output logic              empty,
  output logic [ADDR_W:0]   depth,
  output logic [2:0]        trap,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);
  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_PUSH = 2'd1;
  localparam logic [1:0] OP_POP  = 2'd2;
  localparam logic [1:0] OP_REPL = 2'd3;

  localparam logic [2:0] TRAP_OVF = 3'd1;
  localparam logic [2:0] TRAP_UNF = 3'd2;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] TWO  = (ADDR_W+1)'(2);

  typedef enum logic [1:0] {IDLE, POP_WAIT, TRAP} state_t;
  state_t state;

  logic accept, is_empty, is_full;

  assign op_ready = (state == IDLE);
  assign accept   = op_valid & op_ready;
  assign is_empty = (depth == '0);
  assign is_full  = (depth == FULL);

  // RAM request. A PUSH spills the old TOS into slot depth-1; a POP of a
  // deep stack fetches slot depth-2, which becomes the new TOS next cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = tos;
    if (accept) begin
      if (op == OP_PUSH && !is_empty && !is_full) begin
        mem_we   = 1'b1;
        mem_addr = ADDR_W'(depth - ONE);
      end else if (op == OP_POP && depth > ONE) begin
        mem_addr = ADDR_W'(depth - TWO);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tos   <= '0;
      depth <= '0;
      empty <= 1'b1;
      trap  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            case (op)
              OP_NOP: ;
              OP_PUSH: begin
                if (is_full) begin
                  trap  <= TRAP_OVF;
                  state <= TRAP;
                end else begin
                  tos   <= op_data;
                  depth <= depth + ONE;
                  empty <= 1'b0;
                end
              end
              OP_POP: begin
                if (is_empty) begin
                  trap  <= TRAP_UNF;
                  state <= TRAP;
                end else begin
                  // Popping the last entry leaves the stale TOS in place.
                  depth <= depth - ONE;
                  empty <= (depth == ONE);
                  if (depth != ONE) state <= POP_WAIT;
                end
              end
              OP_REPL: begin
                if (is_empty) begin
                  trap  <= TRAP_UNF;
                  state <= TRAP;
                end else begin
                  tos <= op_data;
                end
              end
              default: ;
            endcase
          end
        end
        POP_WAIT: begin
          tos   <= mem_rdata;
          state <= IDLE;
        end
        default: ;  // TRAP holds everything until reset
      endcase
    end
  end
endmodule

// File: tb/tb_stack_ctrl.sv
module tb_stack_ctrl;
  localparam int WIDTH  = 64;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 0;
  logic              reset = 1;
  logic              op_valid = 0;
  logic [1:0]        op = 0;
  logic [WIDTH-1:0]  op_data = 0;
  logic              op_ready;
  logic [WIDTH-1:0]  tos;
  logic              empty;
  logic [ADDR_W:0]   depth;
  logic [2:0]        trap;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata = 0;

  int checks = 0;
  int errors = 0;
  bit en = 0;

  always #5 clk = ~clk;

  stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .op_data(op_data),
    .op_ready(op_ready), .tos(tos), .empty(empty), .depth(depth), .trap(trap),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // External RAM: synchronous write, registered read.
  logic [WIDTH-1:0] ram [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the stack as a queue (bottom..top), a separately kept
  // visible TOS (stale after popping the last entry), a pending-refill flag
  // and the trap code.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_tos = 0;
  bit               m_pend = 0;
  int               m_trap = 0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete(); m_tos = 0; m_pend = 0; m_trap = 0;
    end else if (m_pend) begin
      m_tos = q[q.size()-1];
      m_pend = 0;
    end else if (m_trap == 0 && op_valid) begin
      case (op)
        2'd1: if (q.size() == DEPTH) m_trap = 1;
              else begin q.push_back(op_data); m_tos = op_data; end
        2'd2: if (q.size() == 0) m_trap = 2;
              else begin
                void'(q.pop_back());
                if (q.size() > 0) m_pend = 1;
              end
        2'd3: if (q.size() == 0) m_trap = 2;
              else begin q[q.size()-1] = op_data; m_tos = op_data; end
        default: ;
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (en) begin
      bit acc, exp_we, exp_rd;
      acc    = op_valid && !m_pend && m_trap == 0;
      exp_we = acc && op == 2'd1 && q.size() > 0 && q.size() < DEPTH;
      exp_rd = acc && op == 2'd2 && q.size() > 1;
      chk("op_ready", op_ready, !m_pend && m_trap == 0);
      chk("tos", tos, m_tos);
      chk("depth", depth, q.size());
      chk("empty", empty, q.size() == 0);
      chk("trap", trap, m_trap);
      chk("mem_we", mem_we, exp_we);
      if (exp_we) begin
        chk("mem_addr_wr", mem_addr, q.size() - 1);
        chk("mem_wdata", mem_wdata, m_tos);
      end
      if (exp_rd) chk("mem_addr_rd", mem_addr, q.size() - 2);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic req(logic [1:0] o, logic [63:0] d);
    op_valid = 1; op = o; op_data = d;
  endtask

  task automatic idle();
    op_valid = 0; op = 0; op_data = 0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); tick(); reset = 0;
  endtask

  initial begin
    do_reset();
    en = 1;
    chk("rst_tos", tos, 0);
    chk("rst_depth", depth, 0);
    chk("rst_empty", empty, 1);
    chk("rst_trap", trap, 0);
    chk("rst_ready", op_ready, 1);
    chk("rst_mem_addr", mem_addr, 0);

    // Three back-to-back pushes.
    req(1, 64'h11); tick();
    req(1, 64'h22); tick();
    req(1, 64'h33); tick();
    idle();
    chk("p3_tos", tos, 64'h33);
    chk("p3_depth", depth, 3);
    chk("p3_empty", empty, 0);
    chk("p3_ram0", ram[0], 64'h11);
    chk("p3_ram1", ram[1], 64'h22);

    // POP from depth 3: read slot 1, refill a cycle later.
    req(2, 0); #1;
    chk("pop1_addr", mem_addr, 1);
    tick(); idle();
    chk("pop1_ready", op_ready, 0);
    chk("pop1_depth", depth, 2);
    tick();
    chk("pop1_tos", tos, 64'h22);
    chk("pop1_ready2", op_ready, 1);
    req(2, 0); tick(); idle(); tick();
    chk("pop2_tos", tos, 64'h11);
    chk("pop2_depth", depth, 1);
    req(2, 0); tick(); idle();
    chk("pop3_depth", depth, 0);
    chk("pop3_empty", empty, 1);
    chk("pop3_ready", op_ready, 1);

    // Push 5, REPLACE with 0.
    req(1, 64'h5); tick();
    req(3, 64'h0); #1;
    chk("repl_we", mem_we, 0);
    tick(); idle();
    chk("repl_tos", tos, 0);
    chk("repl_depth", depth, 1);
    chk("repl_empty", empty, 0);

    // Fill to DEPTH=4, then overflow.
    req(1, 64'hA1); tick();
    req(1, 64'hA2); tick();
    req(1, 64'hA3); tick();
    chk("full_depth", depth, 4);
    req(1, 64'hA4); #1;
    chk("ovf_we", mem_we, 0);
    tick(); idle();
    chk("ovf_trap", trap, 1);
    chk("ovf_depth", depth, 4);
    chk("ovf_tos", tos, 64'hA3);
    chk("ovf_ready", op_ready, 0);
    chk("ovf_ram2", ram[2], 64'hA2);
    tick();
    chk("ovf_sticky", trap, 1);

    // Underflow on an empty stack; later PUSH ignored.
    do_reset();
    req(2, 0); tick(); idle();
    chk("unf_trap", trap, 2);
    chk("unf_ready", op_ready, 0);
    req(1, 64'h77); tick(); tick(); idle();
    chk("unf_sticky", trap, 2);
    chk("unf_depth", depth, 0);

    // Reset while a refill is pending.
    do_reset();
    req(1, 64'hB1); tick();
    req(1, 64'hB2); tick();
    req(2, 0); tick(); idle();
    chk("rpw_ready", op_ready, 0);
    reset = 1; tick(); reset = 0;
    chk("rpw_tos", tos, 0);
    chk("rpw_depth", depth, 0);
    chk("rpw_empty", empty, 1);
    chk("rpw_trap", trap, 0);
    chk("rpw_ready", op_ready, 1);
    tick(); tick();
    chk("rpw_tos2", tos, 0);

    en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
